text_console: RTL

Text-mode pixel source for the 240x240 ST7789 path. Holds a 30x30 grid of 8x8 glyphs in character RAM, accepts characters (typically decoded keyboard input) through a valid/ready write port, and converts beam coordinates from the `vga` timing generator into RGB565 pixels for `lcd_video`. Sync and blank are delayed so they stay aligned with the colour.

---
 rtl/text_console.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/text_console.sv
// text_console: 30x30 grid of 8x8 glyphs rendered as RGB565 for the 240x240 panel.
// The console FSM writes characters into a 1024x8 char RAM through a valid/ready
// port. A 4-stage pipeline turns beam coordinates into pixels, and sync/blank
// travel alongside so they stay aligned with the colour.
// Build option: define TEXT_CONSOLE_CURSOR_EN for a blinking inverted cursor cell.
// c_font_data holds the 2048x8 glyph image that the build flow generates from
// c_font_file. Glyph g, row r sits at g*8+r, and bit 7 is the leftmost pixel.
//
// state     | meaning
// ----------+------------------------------------------------------------
// CLEAR_ALL | writing 0x20 to every char RAM address, 0..1023
// IDLE      | accepting characters (wr_ready=1)
// CLEAR_ROW | writing 0x20 to the 30 cells of the row just advanced into
module text_console #(
  parameter string              c_font_file = "font8x8.mem",
  parameter logic [15:0]        c_fg        = 16'hFFFF,
  parameter logic [15:0]        c_bg        = 16'h0000,
  parameter int                 c_blink_bit = 4,
  parameter logic [0:2047][7:0] c_font_data = '0
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [11:0] beam_x,
  input  logic [7:0]  beam_y,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        blank_i,
  input  logic        wr_valid,
  input  logic [7:0]  wr_char,
  output logic        wr_ready,
  output logic [15:0] color,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_o,
  output logic [4:0]  cur_col,
  output logic [4:0]  cur_row
);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

  localparam logic [7:0] c_space = 8'h20;

  // row*30 + col without a multiplier
  function automatic logic [9:0] cell_addr(input logic [4:0] row, input logic [4:0] col);
    return ({5'd0, row} << 5) - ({5'd0, row} << 1) + {5'd0, col};
  endfunction

  state_t     state, state_nx;
  logic [9:0] clr_addr, clr_addr_nx;
  logic [9:0] clr_left, clr_left_nx;
  logic [4:0] col_nx, row_nx;
  logic [4:0] col_m1;
  logic       advance;
  logic       ram_we;
  logic [9:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [7:0] char_ram [1024];

  assign col_m1 = cur_col - 5'd1;

  // console FSM: next state, cursor update and char RAM write request
  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    clr_left_nx = clr_left;
    col_nx      = cur_col;
    row_nx      = cur_row;
    advance     = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = clr_addr;
    ram_wdata   = c_space;
    wr_ready    = 1'b0;
    case (state)
      CLEAR_ALL, CLEAR_ROW: begin
        ram_we      = 1'b1;
        clr_addr_nx = clr_addr + 10'd1;
        clr_left_nx = clr_left - 10'd1;
        if (clr_left == 10'd0) state_nx = IDLE;
      end
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          if (wr_char >= 8'h20) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(cur_row, cur_col);
            ram_wdata = wr_char;
            if (cur_col == 5'd29) begin
              col_nx  = 5'd0;
              advance = 1'b1;
            end else begin
              col_nx = cur_col + 5'd1;
            end
          end else if (wr_char == 8'h0A || wr_char == 8'h0D) begin
            col_nx  = 5'd0;
            advance = 1'b1;
          end else if (wr_char == 8'h08) begin
            if (cur_col != 5'd0) begin
              col_nx    = col_m1;
              ram_we    = 1'b1;
              ram_waddr = cell_addr(cur_row, col_m1);
            end
          end else if (wr_char == 8'h0C) begin
            col_nx      = 5'd0;
            row_nx      = 5'd0;
            state_nx    = CLEAR_ALL;
            clr_addr_nx = 10'd0;
            clr_left_nx = 10'd1023;
          end
          // no scrolling: the new row is simply blanked before reuse
          if (advance) begin
            row_nx      = (cur_row == 5'd29) ? 5'd0 : cur_row + 5'd1;
            state_nx    = CLEAR_ROW;
            clr_addr_nx = cell_addr(row_nx, 5'd0);
            clr_left_nx = 10'd29;
          end
        end
      end
      default: state_nx = CLEAR_ALL;
    endcase
  end

  // console FSM state, clear counters and cursor registers
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state    <= CLEAR_ALL;
      clr_addr <= 10'd0;
      clr_left <= 10'd1023;
      cur_col  <= 5'd0;
      cur_row  <= 5'd0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
      clr_left <= clr_left_nx;
      cur_col  <= col_nx;
      cur_row  <= row_nx;
    end
  end

  // cursor hit for the current beam position, decided in S1
  logic cur_hit;
`ifdef TEXT_CONSOLE_CURSOR_EN
  logic [7:0] frame_cnt;
  logic       vsync_d;

  // frame counter advances on each vsync_i rising edge
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      frame_cnt <= 8'd0;
      vsync_d   <= 1'b0;
    end else begin
      vsync_d <= vsync_i;
      if (vsync_i && !vsync_d) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign cur_hit = frame_cnt[c_blink_bit] && (beam_x[11:8] == 4'd0) &&
                   (beam_x[7:3] == cur_col) && (beam_y[7:3] == cur_row);
`else
  assign cur_hit = 1'b0;
`endif

  logic [9:0] s1_addr;
  logic [2:0] s1_xl, s1_yl, s2_xl, s2_yl, s3_xl;
  logic       s1_out, s2_out, s3_out;
  logic       s1_cur, s2_cur, s3_cur;
  logic       s1_hs, s2_hs, s3_hs;
  logic       s1_vs, s2_vs, s3_vs;
  logic       s1_bl, s2_bl, s3_bl;
  logic [7:0] s2_char;
  logic [7:0] s3_bits;
  logic       pix_on;

  // char RAM write port plus the unreset data stages (S2 RAM read, S3 font read)
  always_ff @(posedge clk_pixel) begin
    if (ram_we) char_ram[ram_waddr] <= ram_wdata;
    s2_char <= char_ram[s1_addr];
    s3_bits <= c_font_data[{s2_char, s2_yl}];
  end

  // render pipeline: coordinates, flags and timing carried through S1..S3
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      s1_addr <= 10'd0;
      s1_xl   <= 3'd0;
      s1_yl   <= 3'd0;
      s1_out  <= 1'b0;
      s1_cur  <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_bl   <= 1'b1;
      s2_xl   <= 3'd0;
      s2_yl   <= 3'd0;
      s2_out  <= 1'b0;
      s2_cur  <= 1'b0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
      s2_bl   <= 1'b1;
      s3_xl   <= 3'd0;
      s3_out  <= 1'b0;
      s3_cur  <= 1'b0;
      s3_hs   <= 1'b0;
      s3_vs   <= 1'b0;
      s3_bl   <= 1'b1;
    end else begin
      s1_addr <= cell_addr(beam_y[7:3], beam_x[7:3]);
      s1_xl   <= beam_x[2:0];
      s1_yl   <= beam_y[2:0];
      s1_out  <= (beam_x >= 12'd240) || (beam_y >= 8'd240);
      s1_cur  <= cur_hit;
      s1_hs   <= hsync_i;
      s1_vs   <= vsync_i;
      s1_bl   <= blank_i;
      s2_xl   <= s1_xl;
      s2_yl   <= s1_yl;
      s2_out  <= s1_out;
      s2_cur  <= s1_cur;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_bl   <= s1_bl;
      s3_xl   <= s2_xl;
      s3_out  <= s2_out;
      s3_cur  <= s2_cur;
      s3_hs   <= s2_hs;
      s3_vs   <= s2_vs;
      s3_bl   <= s2_bl;
    end
  end

  assign pix_on = s3_bits[3'd7 - s3_xl] ^ s3_cur;

  // S4: pixel select and output registers; blank wins over everything
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      color   <= 16'h0000;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      blank_o <= 1'b1;
    end else begin
      if (s3_bl)       color <= 16'h0000;
      else if (s3_out) color <= c_bg;
      else             color <= pix_on ? c_fg : c_bg;
      hsync_o <= s3_hs;
      vsync_o <= s3_vs;
      blank_o <= s3_bl;
    end
  end

endmodule
